ppfifo_writer: RTL and testbench

- Write-side controller for the ping-pong FIFO.
- Accepts a valid/ready stream with an end-of-packet flag from an upstream producer.
- Claims whichever ping-pong half is free, fills it, and releases it so the read side can drain it.
- Releases a half on any of: half full, packet end, explicit flush, or input idle timeout.
- Runs entirely in the FIFO's write clock domain.

---
 rtl/ppfifo_pkg.sv | 36 +++
 rtl/ppfifo_writer.sv | 155 +++++++++++++++
 tb/tb_ppfifo_writer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppfifo_pkg.sv
// Shared definitions for the ping-pong FIFO write-side controller.
//   state_e      : controller FSM encoding (IDLE, ACTIVE, RELEASE)
//   COUNT_WIDTH  : default width of FIFO size/count values
//   HALF0/HALF1  : one-hot half-select values driven on write_activate
//   pick_half()  : choose which free half to claim
package ppfifo_pkg;

  localparam int COUNT_WIDTH = 24;

  localparam logic [1:0] HALF_NONE = 2'b00;
  localparam logic [1:0] HALF0     = 2'b01;
  localparam logic [1:0] HALF1     = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // A single free half is taken as-is. When both are free the preferred half
  // (the one opposite the last release) wins, so the halves alternate.
  function automatic logic [1:0] pick_half(input logic [1:0] ready,
                                           input logic       prefer_half1);
    logic [1:0] sel;
    sel = HALF_NONE;
    if (ready == HALF0) begin
      sel = HALF0;
    end else if (ready == HALF1) begin
      sel = HALF1;
    end else if (ready == 2'b11) begin
      sel = prefer_half1 ? HALF1 : HALF0;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ppfifo_writer.sv
// Write-side controller for a ping-pong FIFO.
// Claims a free half, streams upstream words into it and releases it on
// half-full, end of packet, flush, or an input idle timeout.
//
// Ports:
//   clk, rst_n        write clock, asynchronous active-low reset
//   in_valid/in_ready upstream stream handshake; in_data, in_last payload
//   flush             release the current half if it holds data
//   write_ready       per-half available flags from the FIFO
//   write_activate    one-hot claimed half (00 = none)
//   write_fifo_size   capacity of each half in words
//   write_strobe      FIFO write enable, write_data its data (1-cycle latency)
//   busy              controller is not idle
//   last_count        word count of the most recently released half
//   dbg_state         current FSM state
//
// Handshake: a word moves when in_valid and in_ready are both high on a rising
// clk edge. in_ready depends only on state, never on in_valid, and the
// producer must hold in_data/in_last stable while in_valid waits for in_ready.
module ppfifo_writer
  import ppfifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int COUNT_WIDTH  = 24,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  input  logic                   flush,
  input  logic [1:0]             write_ready,
  output logic [1:0]             write_activate,
  input  logic [COUNT_WIDTH-1:0] write_fifo_size,
  output logic                   write_strobe,
  output logic [DATA_WIDTH-1:0]  write_data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] last_count,
  output logic [1:0]             dbg_state
);

  // The timer only needs to reach IDLE_TIMEOUT-1; it saturates at all-ones.
  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (IDLE_TIMEOUT > 0) ? TW'(IDLE_TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  state_e                 state_q, state_d;
  logic [1:0]             activate_q, activate_d;
  logic                   strobe_q, strobe_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] last_count_q, last_count_d;
  // Holds the half to prefer next: set to "half 1" after half 0 is released.
  logic                   alt_q, alt_d;

  logic                   xfer;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   timed_out;
  logic                   release_now;
  logic [1:0]             claim;

  assign xfer      = in_valid && (state_q == ACTIVE);
  assign count_inc = count_q + 1'b1;
  assign claim     = pick_half(write_ready, alt_q);

  // Timeout only fires on a partially filled half and never on a cycle that
  // moves a word, since a transfer restarts the idle window.
  assign timed_out = (IDLE_TIMEOUT != 0) && (count_q != '0) && !xfer &&
                     (timer_q == TIMER_LAST);

  // All release causes are OR-ed, so simultaneous causes give one release.
  assign release_now = (xfer && ((count_inc == write_fifo_size) || in_last)) ||
                       (flush && ((count_q != '0) || xfer)) ||
                       timed_out;

  always_comb begin
    state_d      = state_q;
    activate_d   = activate_q;
    strobe_d     = 1'b0;
    data_d       = data_q;
    count_d      = count_q;
    timer_d      = timer_q;
    last_count_d = last_count_q;
    alt_d        = alt_q;
    case (state_q)
      IDLE: begin
        if ((claim != HALF_NONE) && (write_fifo_size != '0)) begin
          activate_d = claim;
          count_d    = '0;
          timer_d    = '0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          data_d   = in_data;
          strobe_d = 1'b1;
          count_d  = count_inc;
          timer_d  = '0;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + 1'b1;
        end
        if (release_now) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // The half stays claimed through this cycle so the registered final
        // strobe lands inside the claim window.
        last_count_d = count_q;
        activate_d   = HALF_NONE;
        alt_d        = activate_q[0];
        state_d      = IDLE;
      end
      default: begin
        state_d    = IDLE;
        activate_d = HALF_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      activate_q   <= HALF_NONE;
      strobe_q     <= 1'b0;
      data_q       <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      last_count_q <= '0;
      alt_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      activate_q   <= activate_d;
      strobe_q     <= strobe_d;
      data_q       <= data_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      last_count_q <= last_count_d;
      alt_q        <= alt_d;
    end
  end

  assign in_ready       = (state_q == ACTIVE);
  assign busy           = (state_q != IDLE);
  assign write_activate = activate_q;
  assign write_strobe   = strobe_q;
  assign write_data     = data_q;
  assign last_count     = last_count_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ppfifo_writer.sv
// Self-checking bench for ppfifo_writer: directed timing scenarios plus a
// randomized packet stream scored against a segment-level reference model.
module tb_ppfifo_writer;
  import ppfifo_pkg::*;

  localparam int DW = 8;
  localparam int CW = ppfifo_pkg::COUNT_WIDTH;
  localparam int TO = 16;
  localparam int NW = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_last, flush;
  logic [DW-1:0] in_data;
  logic [1:0]    write_ready;
  logic [CW-1:0] write_fifo_size;

  logic          in_ready, write_strobe, busy;
  logic [1:0]    write_activate, dbg_state;
  logic [DW-1:0] write_data;
  logic [CW-1:0] last_count;

  // Second instance with the timeout disabled, driven by the same inputs.
  logic          in_ready0, write_strobe0, busy0;
  logic [1:0]    write_activate0, dbg_state0;
  logic [DW-1:0] write_data0;
  logic [CW-1:0] last_count0;

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  int            seg_q[$];
  logic          sb_en = 1'b0;
  logic [1:0]    prev_act;
  logic [1:0]    exp_half;
  int            seg_words;

  ppfifo_writer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .IDLE_TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .flush(flush),
    .write_ready(write_ready), .write_activate(write_activate),
    .write_fifo_size(write_fifo_size), .write_strobe(write_strobe),
    .write_data(write_data), .busy(busy), .last_count(last_count),
    .dbg_state(dbg_state)
  );

  ppfifo_writer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .IDLE_TIMEOUT(0)) u_dut_noto (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .flush(flush),
    .write_ready(write_ready), .write_activate(write_activate0),
    .write_fifo_size(write_fifo_size), .write_strobe(write_strobe0),
    .write_data(write_data0), .busy(busy0), .last_count(last_count0),
    .dbg_state(dbg_state0)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; returns at the falling edge where outputs are stable.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One word that must be accepted on the very next edge.
  task automatic xfer_check(input string tag, input logic [DW-1:0] d,
                            input logic l, input logic f);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    flush    = f;
    check_eq({tag, "_ready"}, in_ready, 1);
    step();
    check_eq({tag, "_strobe"}, write_strobe, 1);
    check_eq({tag, "_data"}, write_data, d);
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
  endtask

  // Hold a word until it is accepted, with a bounded wait.
  task automatic send_word(input logic [DW-1:0] d, input logic l, input logic f,
                           output logic ok);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    flush    = f;
    ok       = 1'b0;
    for (int n = 0; n < 64; n++) begin
      ok = in_ready;
      step();
      if (ok) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (sb_en) begin
      if (write_strobe) begin
        check_eq("sb_strobe_claimed", (write_activate != 2'b00), 1);
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_word", 1, 0);
        end else begin
          check_eq("sb_data", write_data, exp_q.pop_front());
        end
        seg_words++;
      end
      if ((prev_act != 2'b00) && (write_activate == 2'b00)) begin
        if (seg_q.size() == 0) begin
          check_eq("sb_unexpected_release", 1, 0);
        end else begin
          int exp_len;
          exp_len = seg_q.pop_front();
          check_eq("sb_seg_len", seg_words, exp_len);
          check_eq("sb_last_count", last_count, exp_len);
        end
        check_eq("sb_half", prev_act, exp_half);
        exp_half  = {exp_half[0], exp_half[1]};
        seg_words = 0;
      end
      prev_act = write_activate;
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] w_data[NW];
  logic          w_last[NW];
  logic          w_flush[NW];
  int            w_gap[NW];

  initial begin
    logic ok;
    int   size, cnt, r;

    write_ready     = 2'b11;
    write_fifo_size = 4;
    do_reset();

    // Reset values
    check_eq("rst_activate", write_activate, 2'b00);
    check_eq("rst_strobe", write_strobe, 0);
    check_eq("rst_data", write_data, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_last_count", last_count, 0);

    // 1: fill a size-4 half back-to-back, then alternate
    step();
    check_eq("t1_claim", write_activate, 2'b01);
    for (int i = 0; i < 4; i++) begin
      xfer_check("t1_word", 8'(8'hA0 + i), 1'b0, 1'b0);
      check_eq("t1_act_held", write_activate, 2'b01);
    end
    check_eq("t1_release_ready", in_ready, 0);
    check_eq("t1_release_busy", busy, 1);
    step();
    check_eq("t1_act_drop", write_activate, 2'b00);
    check_eq("t1_last_count", last_count, 4);
    check_eq("t1_strobe_off", write_strobe, 0);
    step();
    check_eq("t1_next_claim", write_activate, 2'b10);

    // 2: packet end on the third word of a size-8 half
    write_fifo_size = 8;
    xfer_check("t2_word", 8'hB0, 1'b0, 1'b0);
    xfer_check("t2_word", 8'hB1, 1'b0, 1'b0);
    xfer_check("t2_word", 8'hB2, 1'b1, 1'b0);
    check_eq("t2_release_ready", in_ready, 0);
    check_eq("t2_act_held", write_activate, 2'b10);
    step();
    check_eq("t2_act_drop", write_activate, 2'b00);
    check_eq("t2_last_count", last_count, 3);
    step();
    check_eq("t2_next_claim", write_activate, 2'b01);

    // 3: idle timeout after two words; disabled timeout never releases
    xfer_check("t3_word", 8'hC0, 1'b0, 1'b0);
    xfer_check("t3_word", 8'hC1, 1'b0, 1'b0);
    for (int k = 1; k < TO; k++) step();
    check_eq("t3_before_timeout", in_ready, 1);
    check_eq("t3_act_before", write_activate, 2'b01);
    step();
    check_eq("t3_timeout_edge", in_ready, 0);
    step();
    check_eq("t3_act_drop", write_activate, 2'b00);
    check_eq("t3_last_count", last_count, 2);
    for (int k = TO + 2; k <= 100; k++) step();
    check_eq("t3_reclaim", write_activate, 2'b10);
    check_eq("t3_noto_act", write_activate0, 2'b01);
    check_eq("t3_noto_busy", busy0, 1);
    check_eq("t3_noto_last", last_count0, 3);

    // 4: flush behaviour
    do_reset();
    write_fifo_size = 8;
    step();
    check_eq("t4_claim", write_activate, 2'b01);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("t4_flush_empty_ready", in_ready, 1);
    step();
    check_eq("t4_flush_empty_act", write_activate, 2'b01);
    for (int i = 0; i < 5; i++) xfer_check("t4_word", 8'(8'hD0 + i), 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("t4_flush_release", in_ready, 0);
    step();
    check_eq("t4_flush_drop", write_activate, 2'b00);
    check_eq("t4_flush_count", last_count, 5);
    step();
    check_eq("t4_claim2", write_activate, 2'b10);
    xfer_check("t4_word", 8'hE0, 1'b0, 1'b0);
    xfer_check("t4_word", 8'hE1, 1'b0, 1'b0);
    xfer_check("t4_word", 8'hE2, 1'b0, 1'b1);
    check_eq("t4_flushx_release", in_ready, 0);
    step();
    check_eq("t4_flushx_count", last_count, 3);
    check_eq("t4_flushx_drop", write_activate, 2'b00);

    // 5: nothing ready / zero size
    do_reset();
    write_ready = 2'b00;
    repeat (5) step();
    check_eq("t5_none_ready", in_ready, 0);
    check_eq("t5_none_busy", busy, 0);
    check_eq("t5_none_act", write_activate, 2'b00);
    write_ready = 2'b10;
    step();
    check_eq("t5_claim_half1", write_activate, 2'b10);
    do_reset();
    write_ready     = 2'b11;
    write_fifo_size = 0;
    repeat (5) step();
    check_eq("t5_size0_act", write_activate, 2'b00);
    check_eq("t5_size0_busy", busy, 0);

    // 6: asynchronous reset mid-fill
    do_reset();
    write_fifo_size = 8;
    step();
    check_eq("t6_claim", write_activate, 2'b01);
    xfer_check("t6_word", 8'h60, 1'b0, 1'b0);
    xfer_check("t6_word", 8'h61, 1'b1, 1'b0);
    step();
    check_eq("t6_last_count", last_count, 2);
    step();
    check_eq("t6_claim2", write_activate, 2'b10);
    xfer_check("t6_word", 8'h62, 1'b0, 1'b0);
    xfer_check("t6_word", 8'h63, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_act", write_activate, 2'b00);
    check_eq("t6_async_strobe", write_strobe, 0);
    check_eq("t6_async_last", last_count, 0);
    check_eq("t6_async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("t6_first_claim", write_activate, 2'b01);

    // 7: randomized packet streams against the segment model
    for (int round = 0; round < 3; round++) begin
      do_reset();
      write_ready = 2'b11;
      size = $urandom_range(1, 6);
      write_fifo_size = CW'(size);
      exp_q.delete();
      seg_q.delete();
      cnt = 0;
      for (int i = 0; i < NW; i++) begin
        w_data[i]  = DW'($urandom_range(0, 255));
        w_last[i]  = ($urandom_range(0, 7) == 0);
        w_flush[i] = ($urandom_range(0, 15) == 0);
        r = $urandom_range(0, 9);
        if (i == NW - 1)  w_gap[i] = TO + 4;
        else if (r == 0)  w_gap[i] = $urandom_range(TO, TO + 4);
        else if (r == 1)  w_gap[i] = TO - 1;
        else              w_gap[i] = $urandom_range(0, 3);
        exp_q.push_back(w_data[i]);
        // A half closes when full, on packet end, on flush, or after an
        // input pause of at least the timeout length.
        cnt++;
        if ((cnt == size) || w_last[i] || w_flush[i] || (w_gap[i] >= TO)) begin
          seg_q.push_back(cnt);
          cnt = 0;
        end
      end
      prev_act  = 2'b00;
      seg_words = 0;
      exp_half  = 2'b01;
      sb_en     = 1'b1;
      for (int i = 0; i < NW; i++) begin
        send_word(w_data[i], w_last[i], w_flush[i], ok);
        if (!ok) check_eq("rand_handshake", ok, 1);
        repeat (w_gap[i]) step();
      end
      repeat (8) step();
      sb_en = 1'b0;
      check_eq("rand_words_left", exp_q.size(), 0);
      check_eq("rand_segs_left", seg_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
